// File: rtl/id_queue.sv
// Decode-stage instruction buffer: circular {pc, instr} queue with
// head-entry field decode, immediate generation and load-use stall.
module id_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          if_valid,
  input  logic [31:0]   if_instr,
  input  logic [31:0]   if_pc,
  output logic          if_ready,
  output logic [4:0]    rs1,
  output logic [4:0]    rs2,
  input  logic [31:0]   reg_a,
  input  logic [31:0]   reg_b,
  input  logic          ex_is_load,
  input  logic [4:0]    ex_load_rd,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [31:0]   id_pc,
  output logic [31:0]   id_instr,
  output logic [6:0]    id_opcode,
  output logic [4:0]    id_rd,
  output logic [2:0]    id_funct3,
  output logic [6:0]    id_funct7,
  output logic [31:0]   id_imm,
  output logic [31:0]   id_rs1_data,
  output logic [31:0]   id_rs2_data,
  output logic          id_illegal,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic        nonempty;
  logic        push;
  logic        pop;
  logic        hazard;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        legal;
  logic [31:0] hi;

  assign hi       = instr_mem_q[rptr_q];
  assign nonempty = (count_q != '0);
  assign if_ready = (count_q != FULL);
  assign count    = count_q;

  assign id_pc       = pc_mem_q[rptr_q];
  assign id_instr    = hi;
  assign id_opcode   = hi[6:0];
  assign id_rd       = hi[11:7];
  assign id_funct3   = hi[14:12];
  assign rs1         = hi[19:15];
  assign rs2         = hi[24:20];
  assign id_funct7   = hi[31:25];
  assign id_rs1_data = reg_a;
  assign id_rs2_data = reg_b;

  always_comb begin
    id_imm   = '0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    legal    = 1'b1;
    case (hi[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
        id_imm = {{20{hi[31]}}, hi[31:20]};
      OP_STORE: begin
        id_imm   = {{20{hi[31]}}, hi[31:25], hi[11:7]};
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        id_imm   = {{19{hi[31]}}, hi[31], hi[7],
                    hi[30:25], hi[11:8], 1'b0};
        uses_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        id_imm   = {hi[31:12], 12'b0};
        uses_rs1 = 1'b0;
      end
      OP_JAL: begin
        id_imm   = {{11{hi[31]}}, hi[31], hi[19:12],
                    hi[20], hi[30:21], 1'b0};
        uses_rs1 = 1'b0;
      end
      OP_OP:
        uses_rs2 = 1'b1;
      default:
        legal = 1'b0;
    endcase
  end

  assign hazard = ex_is_load && (ex_load_rd != 5'd0) &&
                  ((uses_rs1 && rs1 == ex_load_rd) ||
                   (uses_rs2 && rs2 == ex_load_rd));

  assign id_illegal = nonempty && !legal;
  assign id_valid   = nonempty && !hazard && !flush;

  assign push = if_valid && if_ready && !flush;
  assign pop  = id_valid && id_ready && !flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Payload storage is never cleared; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wptr_q]    <= if_pc;
      instr_mem_q[wptr_q] <= if_instr;
    end
  end

endmodule

// File: tb/tb_id_queue.sv
// Scenario bench for id_queue with a reference queue model.
module tb_id_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst, flush, if_valid, if_ready;
  logic [31:0]   if_instr, if_pc;
  logic [4:0]    rs1, rs2;
  logic [31:0]   reg_a, reg_b;
  logic          ex_is_load;
  logic [4:0]    ex_load_rd;
  logic          id_valid, id_ready;
  logic [31:0]   id_pc, id_instr, id_imm, id_rs1_data, id_rs2_data;
  logic [6:0]    id_opcode, id_funct7;
  logic [4:0]    id_rd;
  logic [2:0]    id_funct3;
  logic          id_illegal;
  logic [CW-1:0] count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  assign reg_a = {27'h5A5A5A5, rs1};
  assign reg_b = {27'h3C3C3C3, rs2};

  id_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .rs1(rs1), .rs2(rs2),
    .reg_a(reg_a), .reg_b(reg_b),
    .ex_is_load(ex_is_load), .ex_load_rd(ex_load_rd),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_instr(id_instr), .id_opcode(id_opcode),
    .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_imm(id_imm), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_illegal(id_illegal),
    .count(count)
  );

  function automatic bit hz_model(input logic [31:0] i);
    bit u1, u2;
    u1 = !(i[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
    u2 = i[6:0] inside {7'b1100011, 7'b0100011, 7'b0110011};
    return ex_is_load && ex_load_rd != 0 &&
           ((u1 && i[19:15] == ex_load_rd) ||
            (u2 && i[24:20] == ex_load_rd));
  endfunction

  task automatic step();
    bit   hz, pu, po;
    ent_t e;
    hz = (sb.size() != 0) && hz_model(sb[0].instr);
    pu = if_valid && sb.size() != DEPTH && !flush;
    po = sb.size() != 0 && !hz && id_ready && !flush;
    e.pc    = if_pc;
    e.instr = if_instr;
    @(posedge clk);
    if (rst || flush) sb.delete();
    else begin
      if (po) void'(sb.pop_front());
      if (pu) sb.push_back(e);
    end
    #1;
  endtask

  task automatic idle();
    flush = 0; if_valid = 0; id_ready = 0;
    ex_is_load = 0; ex_load_rd = 0; rst = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; if_valid = 1; if_pc = 32'h40; if_instr = 32'h13;
    step();
    step();
    rst = 0; if_valid = 0; #1;
    checks++;
    if (count !== '0) begin failures++;
      $display("FAIL reset_count got=%0d exp=0", count); end
    checks++;
    if (id_valid !== 1'b0) begin failures++;
      $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
    checks++;
    if (if_ready !== 1'b1) begin failures++;
      $display("FAIL reset_if_ready got=%b exp=1", if_ready); end
    checks++;
    if (id_illegal !== 1'b0) begin failures++;
      $display("FAIL reset_illegal got=%b exp=0", id_illegal); end
  endtask

  task automatic test_fill();
    idle();
    for (int i = 0; i < 5; i++) begin
      if_valid = 1; if_pc = 32'(i*4); if_instr = 32'h00000013; #1;
      if (i == 4) begin
        checks++;
        if (if_ready !== 1'b0) begin failures++;
          $display("FAIL fill_fifth_ready got=%b exp=0", if_ready); end
      end
      step();
    end
    if_valid = 0; #1;
    checks++;
    if (count !== CW'(4)) begin failures++;
      $display("FAIL fill_count got=%0d exp=4", count); end
    checks++;
    if (id_pc !== 32'h0 || sb[0].pc !== id_pc) begin failures++;
      $display("FAIL fill_head_pc got=%h exp=00000000", id_pc); end
    checks++;
    if (sb.size() != 4 || sb[3].pc !== 32'h0C) begin failures++;
      $display("FAIL fill_model got=%0d exp=4", sb.size()); end
    flush = 1; step(); flush = 0;
  endtask

  task automatic test_wrap();
    int   pushed = 0, popped = 0;
    logic [31:0] nxt = 32'h0;
    idle();
    id_ready = 1;
    for (int c = 0; c < 20 && popped < 6; c++) begin
      if_valid = (pushed < 6);
      if_pc    = 32'(pushed*4);
      if_instr = 32'h00000013 | (32'(pushed) << 7);
      #1;
      if (sb.size() != 0) begin
        checks++;
        if (id_valid !== 1'b1 || id_pc !== nxt ||
            id_instr !== sb[0].instr) begin failures++;
          $display("FAIL wrap_order got=%h exp=%h", id_pc, nxt); end
        nxt += 4; popped++;
      end
      if (if_valid && sb.size() != DEPTH) pushed++;
      step();
    end
    if_valid = 0; #1;
    checks++;
    if (popped != 6) begin failures++;
      $display("FAIL wrap_timeout got=%0d exp=6", popped); end
    checks++;
    if (count !== '0) begin failures++;
      $display("FAIL wrap_count got=%0d exp=0", count); end
  endtask

  task automatic test_imm();
    logic [31:0] ins [3];
    logic [31:0] exp [3];
    ins[0] = 32'hFFC10113; exp[0] = 32'hFFFFFFFC;
    ins[1] = 32'hFE000EE3; exp[1] = 32'hFFFFFFFC;
    ins[2] = 32'h123450B7; exp[2] = 32'h12345000;
    idle();
    for (int i = 0; i < 3; i++) begin
      if_valid = 1; if_pc = 32'h100 + 32'(i*4); if_instr = ins[i];
      step();
    end
    if_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (id_imm !== exp[i]) begin failures++;
        $display("FAIL imm_%0d got=%h exp=%h", i, id_imm, exp[i]); end
      checks++;
      if (id_instr !== sb[0].instr || id_rd !== ins[i][11:7] ||
          id_rs1_data !== {27'h5A5A5A5, ins[i][19:15]})
      begin failures++;
        $display("FAIL fields_%0d got=%h exp=%h", i, id_instr, ins[i]);
      end
      id_ready = 1; step(); id_ready = 0;
    end
  endtask

  task automatic test_load_use();
    idle();
    ex_is_load = 1; ex_load_rd = 5'd2; id_ready = 1;
    if_valid = 1; if_pc = 32'h200; if_instr = 32'h00208033;
    #1;
    checks++;
    if (id_valid !== 1'b0) begin failures++;
      $display("FAIL no_bypass got=%b exp=0", id_valid); end
    step();
    if_valid = 0; #1;
    checks++;
    if (id_valid !== 1'b0) begin failures++;
      $display("FAIL lu_stall got=%b exp=0", id_valid); end
    step();
    checks++;
    if (id_valid !== 1'b0 || count !== CW'(1) ||
        id_instr !== 32'h00208033 || id_rs2_data !== {27'h3C3C3C3, 5'd2})
    begin failures++;
      $display("FAIL lu_hold got=%h exp=00208033", id_instr); end
    ex_load_rd = 5'd0; #1;
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h200) begin failures++;
      $display("FAIL lu_release got=%b exp=1", id_valid); end
    step();
    checks++;
    if (count !== CW'(sb.size())) begin failures++;
      $display("FAIL lu_pop got=%0d exp=%0d", count, sb.size()); end
  endtask

  task automatic test_flush();
    idle();
    for (int i = 0; i < 3; i++) begin
      if_valid = 1; if_pc = 32'h300 + 32'(i*4); if_instr = 32'h13;
      step();
    end
    id_ready = 1; flush = 1; #1;
    checks++;
    if (id_valid !== 1'b0) begin failures++;
      $display("FAIL flush_same_cycle got=%b exp=0", id_valid); end
    step();
    flush = 0; if_valid = 0; id_ready = 0; #1;
    checks++;
    if (count !== '0 || id_valid !== 1'b0 || if_ready !== 1'b1)
    begin failures++;
      $display("FAIL flush_state got=%0d exp=0", count); end
  endtask

  task automatic test_back_to_back();
    idle();
    for (int i = 0; i < 4; i++) begin
      if_valid = 1; if_pc = 32'h400 + 32'(i*4); if_instr = 32'h13;
      step();
    end
    if_pc = 32'h410; id_ready = 1; #1;
    checks++;
    if (if_ready !== 1'b0 || id_valid !== 1'b1) begin failures++;
      $display("FAIL full_pop_ready got=%b exp=0", if_ready); end
    step();
    if_pc = 32'h414; #1;
    checks++;
    if (count !== CW'(3) || id_pc !== 32'h404) begin failures++;
      $display("FAIL full_pop_count got=%0d exp=3", count); end
    step();
    if_valid = 0; #1;
    checks++;
    if (count !== CW'(3) || id_pc !== sb[0].pc) begin failures++;
      $display("FAIL pushpop_count got=%0d exp=3", count); end
    flush = 1; step(); flush = 0;
  endtask

  task automatic test_illegal_reset();
    idle();
    if_valid = 1; if_pc = 32'h500; if_instr = 32'h0000000B;
    step();
    if_valid = 0; #1;
    checks++;
    if (id_illegal !== 1'b1 || id_valid !== 1'b1) begin failures++;
      $display("FAIL illegal got=%b exp=1", id_illegal); end
    rst = 1; if_valid = 1; if_instr = 32'h13;
    step();
    rst = 0; if_valid = 0; #1;
    checks++;
    if (count !== '0 || id_valid !== 1'b0 || id_illegal !== 1'b0)
    begin failures++;
      $display("FAIL mid_reset got=%0d exp=0", count); end
  endtask

  initial begin
    idle();
    if_pc = 0; if_instr = 0;
    test_reset();
    test_fill();
    test_wrap();
    test_imm();
    test_load_use();
    test_flush();
    test_back_to_back();
    test_illegal_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
